// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// A synchronised scan_clk rising edge advances one digit. The display value
// is latched at each frame start, so a frame never shows a mix of old and new values.
module seg_display_scanner #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        scan_clk,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out
);

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned VAL_W  = DIGITS * NIB_W;
    localparam int unsigned IDX_W  = 2;

    // XOR masks that apply output polarity; they also equal the off level.
    localparam logic [DIGITS-1:0] AN_POL  = ACTIVE_LOW ? {DIGITS{1'b1}} : '0;
    localparam logic [SEG_W-1:0]  SEG_POL = ACTIVE_LOW ? {SEG_W{1'b1}}  : '0;
    localparam logic              DP_POL  = ACTIVE_LOW;

    logic              s1, s2, s3;
    logic              step_c;
    logic [IDX_W-1:0]  idx, idx_d, nidx_c;
    logic [VAL_W-1:0]  shadow, shadow_d, frame_c;
    logic [DIGITS-1:0] dp_sh, dp_sh_d, frame_dp_c;
    logic [NIB_W-1:0]  nib_c;
    logic              lz_c, blanked_c;
    logic              z1_c, z2_c, z3_c;
    logic [DIGITS-1:0] an_d;
    logic [SEG_W-1:0]  seg_d;
    logic              dp_d;

    // Active-high hex decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] hex_decode(input logic [NIB_W-1:0] n);
        logic [SEG_W-1:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= scan_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_c = s2 & ~s3;

    // Next digit selection, frame latch, blanking and decode.
    always_comb begin
        idx_d      = idx;
        shadow_d   = shadow;
        dp_sh_d    = dp_sh;
        an_d       = an;
        seg_d      = seg;
        dp_d       = dp_out;
        nidx_c     = IDX_W'(idx + IDX_W'(1));
        // Digit 0 shows the value captured on this very step, not the old shadow.
        frame_c    = (nidx_c == '0) ? value : shadow;
        frame_dp_c = (nidx_c == '0) ? dp    : dp_sh;
        nib_c      = NIB_W'(frame_c >> {nidx_c, 2'b00});
        z3_c       = (frame_c[15:12] == '0);
        z2_c       = z3_c & (frame_c[11:8] == '0);
        z1_c       = z2_c & (frame_c[7:4] == '0);
        case (nidx_c)
            2'd1:    lz_c = z1_c;
            2'd2:    lz_c = z2_c;
            2'd3:    lz_c = z3_c;
            default: lz_c = 1'b0;
        endcase
        blanked_c = blank_lz & lz_c;

        if (step_c) begin
            if (en) begin
                idx_d = nidx_c;
                if (nidx_c == '0) begin
                    shadow_d = value;
                    dp_sh_d  = dp;
                end
                an_d  = DIGITS'(4'b0001 << nidx_c) ^ AN_POL;
                seg_d = (blanked_c ? '0 : hex_decode(nib_c)) ^ SEG_POL;
                dp_d  = frame_dp_c[nidx_c] ^ DP_POL;
            end else begin
                an_d  = AN_POL;
                seg_d = SEG_POL;
                dp_d  = DP_POL;
            end
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= IDX_W'(3);
            shadow <= '0;
            dp_sh  <= '0;
            an     <= AN_POL;
            seg    <= SEG_POL;
            dp_out <= DP_POL;
        end else begin
            idx    <= idx_d;
            shadow <= shadow_d;
            dp_sh  <= dp_sh_d;
            an     <= an_d;
            seg    <= seg_d;
            dp_out <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner with ACTIVE_LOW = 1.
module tb_seg_display_scanner;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic        en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [11:0] exp_q[$];
    logic [11:0] cur;
    localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};

    seg_display_scanner #(.ACTIVE_LOW(1'b1)) dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .scan_clk(scan_clk),
        .en      (en),
        .value   (value),
        .dp      (dp),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .dp_out  (dp_out)
    );

    always #5 clkin = ~clkin;

    // Reference hex font, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Expected active-low {an,seg,dp_out} for digit i of a frame.
    function automatic logic [11:0] model(input logic [15:0] v, input logic [3:0] d,
                                          input logic b, input int i);
        logic [15:0] above;
        logic [3:0]  onehot;
        logic [6:0]  s;
        above  = v >> (4 * i);
        onehot = 4'b0001 << i;
        s      = (b && i > 0 && above == 16'h0) ? 7'h00 : font(above[3:0]);
        return {~onehot, ~s, ~d[i]};
    endfunction

    // One scan_clk rise; output must hold through edge 2 and update on edge 3.
    task automatic do_step(input logic [11:0] e, input string name);
        logic [11:0] want;
        exp_q.push_back(e);
        @(negedge clkin);
        scan_clk = 1'b1;
        repeat (2) @(posedge clkin);
        #1;
        checks++;
        if ({an, seg, dp_out} !== cur) begin
            failures++;
            $display("FAIL %s_hold: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, an, seg, dp_out, cur[11:8], cur[7:1], cur[0]);
        end
        @(posedge clkin);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = exp_q.pop_front();
            if ({an, seg, dp_out} !== want) begin
                failures++;
                $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         name, an, seg, dp_out, want[11:8], want[7:1], want[0]);
            end
            cur = want;
        end
        @(negedge clkin);
        scan_clk = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clkin);
        checks++;
        if ({an, seg, dp_out} !== OFF) begin
            failures++;
            $display("FAIL reset: got an=%b seg=%h dp=%b, expected 1111/7f/1", an, seg, dp_out);
        end
        rst_n = 1'b1;
        cur = OFF;
        repeat (2) @(negedge clkin);
    endtask

    task automatic test_first_step();
        value = 16'h1234; en = 1'b1; dp = 4'h0; blank_lz = 1'b0;
        do_step({4'b1110, 7'h19, 1'b1}, "first_d0");
        do_step({4'b1101, 7'h30, 1'b1}, "first_d1");
        do_step({4'b1011, 7'h24, 1'b1}, "first_d2");
        do_step({4'b0111, 7'h79, 1'b1}, "first_d3");
    endtask

    task automatic test_full_scan();
        logic [11:0] seq [4];
        seq[0] = {4'b1110, 7'h0E, 1'b1};
        seq[1] = {4'b1101, 7'h40, 1'b1};
        seq[2] = {4'b1011, 7'h03, 1'b1};
        seq[3] = {4'b0111, 7'h08, 1'b1};
        value = 16'hAB0F;
        for (int i = 0; i < 8; i++) do_step(seq[i % 4], "full_scan");
    endtask

    task automatic test_tear_free();
        value = 16'h1111;
        do_step({4'b1110, 7'h79, 1'b1}, "tear_d0");
        do_step({4'b1101, 7'h79, 1'b1}, "tear_d1");
        value = 16'h2222;
        do_step({4'b1011, 7'h79, 1'b1}, "tear_d2_old");
        do_step({4'b0111, 7'h79, 1'b1}, "tear_d3_old");
        do_step({4'b1110, 7'h24, 1'b1}, "tear_d0_new");
        do_step({4'b1101, 7'h24, 1'b1}, "tear_d1_new");
        do_step({4'b1011, 7'h24, 1'b1}, "tear_d2_new");
        do_step({4'b0111, 7'h24, 1'b1}, "tear_d3_new");
    endtask

    task automatic test_lz_blank();
        value = 16'h0040; blank_lz = 1'b1; dp = 4'b1000;
        do_step({4'b1110, 7'h40, 1'b1}, "lz_d0");
        do_step({4'b1101, 7'h19, 1'b1}, "lz_d1");
        do_step({4'b1011, 7'h7F, 1'b1}, "lz_d2");
        do_step({4'b0111, 7'h7F, 1'b0}, "lz_d3");
    endtask

    task automatic test_enable();
        value = 16'h5678; blank_lz = 1'b0; dp = 4'h0;
        do_step({4'b1110, 7'h00, 1'b1}, "en_d0");
        do_step({4'b1101, 7'h78, 1'b1}, "en_d1");
        do_step({4'b1011, 7'h02, 1'b1}, "en_d2");
        en = 1'b0;
        do_step(OFF, "en_off");
        do_step(OFF, "en_off_hold");
        en = 1'b1;
        do_step({4'b0111, 7'h12, 1'b1}, "en_resume_d3");
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [3:0]  d;
        logic        b;
        for (int f = 0; f < 4; f++) begin
            v = 16'($urandom);
            if (f == 1) v = 16'h000A;
            if (f == 2) v = 16'h0300;
            d = 4'($urandom);
            b = (f != 3);
            value = v; dp = d; blank_lz = b;
            for (int i = 0; i < 4; i++) begin
                do_step(model(v, d, b, i), "back_to_back");
                value = 16'($urandom);
                dp = 4'($urandom);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clkin);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp_out} !== OFF) begin
            failures++;
            $display("FAIL async_reset: got an=%b seg=%h dp=%b, expected 1111/7f/1", an, seg, dp_out);
        end
        cur = OFF;
        @(negedge clkin);
        rst_n = 1'b1;
        value = 16'h00C0; dp = 4'b0001; blank_lz = 1'b0;
        repeat (2) @(negedge clkin);
        do_step({4'b1110, 7'h40, 1'b0}, "post_reset_d0");
        do_step({4'b1101, 7'h46, 1'b1}, "post_reset_d1");
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_full_scan();
        test_tear_free();
        test_lz_blank();
        test_enable();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
